// File: rtl/i3c_pkg.sv
// Shared I3C/HCI types: command attributes, response status, response descriptor
// and the command decoder state encoding.
package i3c_pkg;

  localparam int CmdWroc = 30;
  localparam int CmdToc  = 31;

  typedef enum logic [2:0] {
    RegularTransfer       = 3'b000,
    ImmediateDataTransfer = 3'b001,
    AddressAssignment     = 3'b010,
    ComboTransfer         = 3'b011,
    InternalControl       = 3'b111
  } i3c_cmd_attr_e;

  typedef enum logic [3:0] {
    Success         = 4'h0,
    Crc             = 4'h1,
    Parity          = 4'h2,
    Frame           = 4'h3,
    AddrHeader      = 4'h4,
    Nack            = 4'h5,
    Ovl             = 4'h6,
    I3cShortReadErr = 4'h7,
    HcAborted       = 4'h8,
    I2cWrDataNack   = 4'h9,
    NotSupported    = 4'hA
  } i3c_resp_err_status_e;

  typedef struct packed {
    i3c_resp_err_status_e err_status;
    logic [3:0]           tid;
    logic [7:0]           rsvd;
    logic [15:0]          data_length;
  } i3c_response_desc_t;

  typedef enum logic [2:0] {
    DecIdle,
    DecFetchDw1,
    DecDispatch,
    DecWaitDone,
    DecRespond
  } hci_cmd_dec_state_e;

  function automatic logic attr_supported(input logic [2:0] attr);
    return i3c_cmd_attr_e'(attr) inside {RegularTransfer, ImmediateDataTransfer, AddressAssignment};
  endfunction

endpackage

// File: rtl/hci_cmd_decoder_if.sv
// Command queue, flow-FSM dispatch, response queue and halt control bundle.
// Suffixes are from the decoder's point of view.
interface hci_cmd_decoder_if;
  logic        cmd_queue_rvalid_i;
  logic        cmd_queue_rready_o;
  logic [31:0] cmd_queue_rdata_i;
  logic        xfer_valid_o;
  logic        xfer_ready_i;
  logic [63:0] xfer_desc_o;
  logic [2:0]  xfer_attr_o;
  logic        xfer_done_i;
  logic [3:0]  xfer_err_i;
  logic [15:0] xfer_len_i;
  logic        abort_o;
  logic        resp_queue_wvalid_o;
  logic        resp_queue_wready_i;
  logic [31:0] resp_queue_wdata_o;
  logic        halted_o;
  logic        resume_i;

  modport slave (
    input  cmd_queue_rvalid_i, cmd_queue_rdata_i, xfer_ready_i, xfer_done_i,
           xfer_err_i, xfer_len_i, resp_queue_wready_i, resume_i,
    output cmd_queue_rready_o, xfer_valid_o, xfer_desc_o, xfer_attr_o, abort_o,
           resp_queue_wvalid_o, resp_queue_wdata_o, halted_o
  );

  modport master (
    output cmd_queue_rvalid_i, cmd_queue_rdata_i, xfer_ready_i, xfer_done_i,
           xfer_err_i, xfer_len_i, resp_queue_wready_i, resume_i,
    input  cmd_queue_rready_o, xfer_valid_o, xfer_desc_o, xfer_attr_o, abort_o,
           resp_queue_wvalid_o, resp_queue_wdata_o, halted_o
  );
endinterface

// File: rtl/hci_xfer_watchdog.sv
// Per-transfer completion counter; tc_o fires in the cycle the count would reach Cycles.
// Cycles == 0 never fires.
module hci_xfer_watchdog #(
  parameter int unsigned Cycles = 65535,
  parameter int unsigned W      = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int unsigned CW = (W < 1) ? 1 : W;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) cnt_q <= '0;
    else if (en_i)        cnt_q <= cnt_q + 1'b1;
  end

  assign tc_o = (Cycles != 0) && en_i && (cnt_q == CW'(Cycles - 1));
endmodule

// File: rtl/hci_cmd_decoder.sv
// Pops two-DWORD HCI command descriptors, dispatches supported ones to the flow FSM,
// and writes a response descriptor; halts on error until resumed.
module hci_cmd_decoder import i3c_pkg::*; #(
  parameter int unsigned TimeoutCycles = 65535,
  parameter int unsigned TimeoutW      = $clog2(TimeoutCycles + 1)
) (
  input logic               clk_i,
  input logic               rst_ni,
  hci_cmd_decoder_if.slave  bus
);
  hci_cmd_dec_state_e state_q, state_d;
  logic [63:0]        desc_q, desc_d;
  logic [2:0]         attr_q, attr_d;
  logic               xvalid_q, xvalid_d;
  logic               abort_q, abort_d;
  logic               wvalid_q, wvalid_d;
  logic               halted_q, halted_d;
  i3c_response_desc_t resp_q, resp_d;
  logic               rready, pop, wd_clr, wd_en, wd_tc;

  hci_xfer_watchdog #(.Cycles(TimeoutCycles), .W(TimeoutW)) u_wd (
    .clk_i, .rst_ni, .clr_i(wd_clr), .en_i(wd_en), .tc_o(wd_tc)
  );

  // Only the pop strobe is combinational; it must be low while reset is held.
  always_comb begin
    rready = 1'b0;
    if (rst_ni) begin
      if (state_q == DecIdle)          rready = !halted_q;
      else if (state_q == DecFetchDw1) rready = 1'b1;
    end
  end
  assign pop = rready && bus.cmd_queue_rvalid_i;

  always_comb begin
    state_d  = state_q;
    desc_d   = desc_q;
    attr_d   = attr_q;
    xvalid_d = xvalid_q;
    abort_d  = 1'b0;
    wvalid_d = wvalid_q;
    resp_d   = resp_q;
    halted_d = bus.resume_i ? 1'b0 : halted_q;
    wd_clr   = 1'b0;
    wd_en    = 1'b0;
    case (state_q)
      DecIdle: if (pop) begin
        desc_d[31:0] = bus.cmd_queue_rdata_i;
        state_d      = DecFetchDw1;
      end
      DecFetchDw1: if (pop) begin
        desc_d[63:32] = bus.cmd_queue_rdata_i;
        attr_d        = desc_q[2:0];
        if (attr_supported(desc_q[2:0])) begin
          xvalid_d = 1'b1;
          state_d  = DecDispatch;
        end else begin
          resp_d   = '{err_status: NotSupported, tid: desc_q[6:3], rsvd: 8'h00, data_length: 16'h0};
          wvalid_d = 1'b1;
          state_d  = DecRespond;
        end
      end
      DecDispatch: if (bus.xfer_ready_i) begin
        xvalid_d = 1'b0;
        wd_clr   = 1'b1;
        state_d  = DecWaitDone;
      end
      DecWaitDone: begin
        wd_en = 1'b1;
        // A completion landing on the terminal cycle beats the abort.
        if (bus.xfer_done_i) begin
          resp_d   = '{err_status: i3c_resp_err_status_e'(bus.xfer_err_i), tid: desc_q[6:3],
                       rsvd: 8'h00, data_length: bus.xfer_len_i};
          wvalid_d = desc_q[CmdWroc] || (bus.xfer_err_i != 4'(Success));
          state_d  = DecRespond;
        end else if (wd_tc) begin
          abort_d  = 1'b1;
          resp_d   = '{err_status: HcAborted, tid: desc_q[6:3], rsvd: 8'h00, data_length: 16'h0};
          wvalid_d = 1'b1;
          state_d  = DecRespond;
        end
      end
      DecRespond: begin
        if (!wvalid_q) state_d = DecIdle;
        else if (bus.resp_queue_wready_i) begin
          wvalid_d = 1'b0;
          state_d  = DecIdle;
          // Setting the halt overrides a coincident resume.
          if (resp_q.err_status != Success) halted_d = 1'b1;
        end
      end
      default: state_d = DecIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= DecIdle;
      desc_q   <= '0;
      attr_q   <= '0;
      xvalid_q <= 1'b0;
      abort_q  <= 1'b0;
      wvalid_q <= 1'b0;
      halted_q <= 1'b0;
      resp_q   <= '0;
    end else begin
      state_q  <= state_d;
      desc_q   <= desc_d;
      attr_q   <= attr_d;
      xvalid_q <= xvalid_d;
      abort_q  <= abort_d;
      wvalid_q <= wvalid_d;
      halted_q <= halted_d;
      resp_q   <= resp_d;
    end
  end

  assign bus.cmd_queue_rready_o  = rready;
  assign bus.xfer_valid_o        = xvalid_q;
  assign bus.xfer_desc_o         = desc_q;
  assign bus.xfer_attr_o         = attr_q;
  assign bus.abort_o             = abort_q;
  assign bus.resp_queue_wvalid_o = wvalid_q;
  assign bus.resp_queue_wdata_o  = resp_q;
  assign bus.halted_o            = halted_q;
endmodule

// File: tb/tb_hci_cmd_decoder.sv
// Directed bench for hci_cmd_decoder with a response scoreboard (TimeoutCycles = 16).
module tb_hci_cmd_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  hci_cmd_decoder_if bus();

  hci_cmd_decoder #(.TimeoutCycles(16)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && bus.resp_queue_wvalid_o && bus.resp_queue_wready_i)
      got_q.push_back(bus.resp_queue_wdata_o);

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w, input string tag);
    int n = 0;
    bus.cmd_queue_rvalid_i = 1'b1;
    bus.cmd_queue_rdata_i  = w;
    while (!bus.cmd_queue_rready_o && n < 100) begin tick(); n++; end
    if (!bus.cmd_queue_rready_o) chk(tag, 64'(bus.cmd_queue_rready_o), 64'd1);
    tick();
    bus.cmd_queue_rvalid_i = 1'b0;
  endtask

  task automatic push_cmd(input logic [31:0] dw0, input logic [31:0] dw1);
    push_word(dw0, "pop_dw0_timeout");
    push_word(dw1, "pop_dw1_timeout");
  endtask

  task automatic dispatch();
    bus.xfer_ready_i = 1'b1;
    tick();
    bus.xfer_ready_i = 1'b0;
  endtask

  task automatic done(input logic [3:0] err, input logic [15:0] len, input int delay);
    repeat (delay) tick();
    bus.xfer_done_i = 1'b1;
    bus.xfer_err_i  = err;
    bus.xfer_len_i  = len;
    tick();
    bus.xfer_done_i = 1'b0;
  endtask

  task automatic expect_resp(input string tag);
    int n = 0;
    while (got_q.size() == 0 && n < 50) begin tick(); n++; end
    if (got_q.size() == 0) chk({tag, "_timeout"}, 64'(got_q.size()), 64'd1);
    else chk(tag, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
  endtask

  task automatic resume();
    bus.resume_i = 1'b1;
    tick();
    bus.resume_i = 1'b0;
  endtask

  initial begin
    int aborts;
    bus.cmd_queue_rvalid_i  = 1'b0;
    bus.cmd_queue_rdata_i   = '0;
    bus.xfer_ready_i        = 1'b0;
    bus.xfer_done_i         = 1'b0;
    bus.xfer_err_i          = '0;
    bus.xfer_len_i          = '0;
    bus.resp_queue_wready_i = 1'b1;
    bus.resume_i            = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_rready", 64'(bus.cmd_queue_rready_o), 64'd0);
    chk("rst_outs", 64'({bus.xfer_valid_o, bus.abort_o, bus.resp_queue_wvalid_o, bus.halted_o}), 64'd0);
    chk("rst_data", 64'({bus.xfer_attr_o, bus.resp_queue_wdata_o}) | bus.xfer_desc_o, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_rready", 64'(bus.cmd_queue_rready_o), 64'd1);

    // Regular write with wroc
    exp_q.push_back(32'h0300_0004);
    push_cmd(32'h4000_0018, 32'h0004_0000);
    chk("t1_xvalid", 64'(bus.xfer_valid_o), 64'd1);
    chk("t1_attr", 64'(bus.xfer_attr_o), 64'd0);
    chk("t1_desc", bus.xfer_desc_o, 64'h0004_0000_4000_0018);
    dispatch();
    chk("t1_xvalid_drop", 64'(bus.xfer_valid_o), 64'd0);
    done(4'd0, 16'd4, 2);
    chk("t1_wvalid_lat", 64'(bus.resp_queue_wvalid_o), 64'd1);
    expect_resp("t1_resp");
    chk("t1_halted", 64'(bus.halted_o), 64'd0);
    chk("t1_turnaround_rready", 64'(bus.cmd_queue_rready_o), 64'd1);

    // Immediate write without wroc: no response
    push_cmd(32'h0100_0029, 32'h1122_3344);
    chk("t2_attr", 64'(bus.xfer_attr_o), 64'd1);
    dispatch();
    done(4'd0, 16'd2, 0);
    chk("t2_no_wvalid", 64'(bus.resp_queue_wvalid_o), 64'd0);
    tick();
    chk("t2_rready", 64'(bus.cmd_queue_rready_o), 64'd1);
    chk("t2_no_resp", 64'(got_q.size()), 64'd0);

    // Unsupported attribute: straight to response, then halt blocks the queue
    exp_q.push_back(32'hA500_0000);
    push_cmd(32'h0000_002B, 32'h0);
    chk("t3_no_xvalid", 64'(bus.xfer_valid_o), 64'd0);
    chk("t3_wvalid", 64'(bus.resp_queue_wvalid_o), 64'd1);
    expect_resp("t3_resp");
    chk("t3_halted", 64'(bus.halted_o), 64'd1);
    bus.cmd_queue_rvalid_i = 1'b1;
    bus.cmd_queue_rdata_i  = 32'h0000_0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_blocked", 64'(bus.cmd_queue_rready_o), 64'd0);
    end
    resume();
    chk("t3_resumed", 64'(bus.halted_o), 64'd0);

    // NACK error on the queued command; resume in the handshake cycle loses to the halt
    exp_q.push_back(32'h5200_0000);
    push_cmd(32'h0000_0010, 32'h0000_0000);
    chk("t4_xvalid", 64'(bus.xfer_valid_o), 64'd1);
    dispatch();
    done(4'd5, 16'd0, 1);
    bus.resume_i = 1'b1;
    tick();
    bus.resume_i = 1'b0;
    chk("t4_halt_wins", 64'(bus.halted_o), 64'd1);
    expect_resp("t4_resp");
    resume();
    chk("t4_resumed", 64'(bus.halted_o), 64'd0);

    // Watchdog expiry
    exp_q.push_back(32'h8700_0000);
    push_cmd(32'h0000_0038, 32'h0);
    dispatch();
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk($sformatf("t5_abort_c%0d", k), 64'(bus.abort_o), 64'(k == 16));
    end
    expect_resp("t5_resp");
    chk("t5_halted", 64'(bus.halted_o), 64'd1);
    resume();

    // Done on the terminal cycle wins over the abort
    exp_q.push_back(32'h0600_0009);
    push_cmd(32'h4000_0030, 32'h0);
    dispatch();
    done(4'd0, 16'd9, 15);
    chk("t6_no_abort", 64'(bus.abort_o), 64'd0);
    chk("t6_wvalid", 64'(bus.resp_queue_wvalid_o), 64'd1);
    tick();
    chk("t6_no_abort_late", 64'(bus.abort_o), 64'd0);
    expect_resp("t6_resp");
    chk("t6_halted", 64'(bus.halted_o), 64'd0);

    // Response backpressure
    exp_q.push_back(32'h0100_0003);
    push_cmd(32'h4000_0008, 32'h0);
    dispatch();
    bus.resp_queue_wready_i = 1'b0;
    done(4'd0, 16'd3, 1);
    for (int i = 0; i < 10; i++) begin
      chk("t7_hold", 64'({bus.resp_queue_wvalid_o, bus.resp_queue_wdata_o}), 64'h1_0100_0003);
      tick();
    end
    chk("t7_not_written", 64'(got_q.size()), 64'd0);
    bus.resp_queue_wready_i = 1'b1;
    expect_resp("t7_resp");

    // Reset during WAIT_DONE discards the transfer
    push_cmd(32'h4000_0020, 32'h0);
    dispatch();
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    chk("t8_rready", 64'(bus.cmd_queue_rready_o), 64'd0);
    chk("t8_outs", 64'({bus.xfer_valid_o, bus.abort_o, bus.resp_queue_wvalid_o, bus.halted_o}), 64'd0);
    chk("t8_data", 64'({bus.xfer_attr_o, bus.resp_queue_wdata_o}) | bus.xfer_desc_o, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("t8_post_rready", 64'(bus.cmd_queue_rready_o), 64'd1);
    aborts = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.abort_o || bus.resp_queue_wvalid_o) aborts++;
      tick();
    end
    chk("t8_quiet", 64'(aborts), 64'd0);

    chk("sb_got_empty", 64'(got_q.size()), 64'd0);
    chk("sb_exp_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hci_cmd_decoder.md
# hci_cmd_decoder

Pulls HCI command descriptors from the 32-bit command queue and assembles each two-DWORD descriptor. It classifies the descriptor by attribute and dispatches supported transfers to the controller flow FSM. After the transfer completes, it packs an `i3c_response_desc_t` into the response queue. It sits between the command/response queues and the controller flow logic, acting as the consumer of what software writes into the command port. It also implements HCI halt-on-error and a per-transfer completion watchdog.

## Interface
Parameters:
- `TimeoutCycles`, default 65535: cycles allowed from dispatch handshake to `xfer_done_i`; 0 disables the watchdog.
- `TimeoutW`, default `$clog2(TimeoutCycles+1)`: width of the watchdog counter.

Ports:
- Clock and reset (already decided): one clock; reset is synchronous and active-low.
  - `clk_i`  in  1  clock.
  - `rst_ni`  in  1  synchronous active-low reset.
- Command queue:
  - `cmd_queue_rvalid_i`  in  1  command queue word available.
  - `cmd_queue_rready_o`  out  1  pop the command queue word.
  - `cmd_queue_rdata_i`  in  32  command word; DWORD0 arrives first, then DWORD1.
- Dispatch to the flow FSM:
  - `xfer_valid_o`  out  1  descriptor offered to the flow FSM.
  - `xfer_ready_i`  in  1  flow FSM accepts the descriptor.
  - `xfer_desc_o`  out  64  raw descriptor, `{DWORD1, DWORD0}`; the consumer casts it with the package struct.
  - `xfer_attr_o`  out  3  `i3c_cmd_attr_e`.
  - `xfer_done_i`  in  1  single-cycle pulse: transfer finished.
  - `xfer_err_i`  in  4  `i3c_resp_err_status_e`; valid with `xfer_done_i`.
  - `xfer_len_i`  in  16  bytes transferred; valid with `xfer_done_i`.
  - `abort_o`  out  1  single-cycle abort request to the flow FSM.
- Response queue:
  - `resp_queue_wvalid_o`  out  1  response word valid.
  - `resp_queue_wready_i`  in  1  response queue accepts the word.
  - `resp_queue_wdata_o`  out  32  response word, `i3c_response_desc_t`.
- Halt control:
  - `halted_o`  out  1  command processing halted after an error.
  - `resume_i`  in  1  pulse: clear the halt.

## Operation
States: IDLE, FETCH_DW1, DISPATCH, WAIT_DONE, RESPOND.
- **IDLE**
  - `cmd_queue_rready_o` = `!halted_o`.
  - On a pop, latch DWORD0 and go to FETCH_DW1.
- **FETCH_DW1**
  - `cmd_queue_rready_o` = 1.
  - On a pop, latch DWORD1, then decode `attr = DWORD0[2:0]` and `tid = DWORD0[6:3]`.
  - `RegularTransfer`, `ImmediateDataTransfer` and `AddressAssignment` go to DISPATCH.
  - Every other code (Combo, InternalControl, reserved) goes to RESPOND with `err = NotSupported` and `len = 0`.
- **DISPATCH**
  - `xfer_valid_o` = 1, with `xfer_desc_o` and `xfer_attr_o` held stable until `xfer_ready_i`.
  - On the handshake, clear the watchdog and go to WAIT_DONE.
- **WAIT_DONE**
  - The watchdog increments every cycle.
  - On `xfer_done_i`, capture `err` and `len`, then go to RESPOND.
  - When the watchdog reaches `TimeoutCycles` (and `TimeoutCycles` ≠ 0), pulse `abort_o` for one cycle and capture `err = HcAborted`, `len = 0`.
  - `xfer_done_i` in the same cycle as the timeout takes priority; no abort is issued.
- **RESPOND**
  - A response is emitted when `wroc = DWORD0[30]` is 1 or `err != Success`. Otherwise, return to IDLE without writing.
  - Response word: `{err[3:0], tid[3:0], 8'h00, len[15:0]}`, held until `resp_queue_wready_i`.
  - When `err != Success`, set `halted_o` on the handshake cycle.
- **Halt**
  - `resume_i` clears `halted_o` in any state.
  - `resume_i` together with a halt-setting handshake in the same cycle: the halt wins, and `halted_o` stays 1.
  - While halted, the FSM finishes the current state and blocks only in IDLE.
- A DWORD0 followed by a missing DWORD1 waits indefinitely in FETCH_DW1; no timeout applies.

## Timing
- Reset values: state IDLE; `cmd_queue_rready_o`=0 during reset, and 1 in the first cycle after reset. `xfer_valid_o`=0, `abort_o`=0, `resp_queue_wvalid_o`=0, `halted_o`=0, and all data outputs 0.
- All outputs are registered, except `cmd_queue_rready_o`, which decodes from state and `halted_o`.
- Minimum latency, from DWORD0 pop to `xfer_valid_o`: 2 cycles (back-to-back pops).
- From `xfer_done_i` to `resp_queue_wvalid_o`: 1 cycle.
- Minimum turnaround, response handshake to the next DWORD0 pop: 1 cycle.
- Reset asserted mid-transfer returns to IDLE in the next cycle and discards the latched descriptor. No response and no abort are produced.

## Structure
- Add to `i3c_pkg`:
  - `hci_cmd_dec_state_e`.
  - `localparam CmdWroc = 30` and `CmdToc = 31`.
- Reuse the existing `i3c_cmd_attr_e`, `i3c_resp_err_status_e` and `i3c_response_desc_t`.
- Split the watchdog into one sub-module, `hci_xfer_watchdog`: a counter with clear/enable and a terminal-count pulse.

## Test plan
- **Regular write with wroc.** DWORD0 `0x4000_0018` (attr 0, tid 3, wroc 1), DWORD1 `0x0004_0000`; done with `err=0`, `len=4` -> response `0x0300_0004`, `halted_o=0`.
- **Immediate write without wroc.** DWORD0 `0x0100_0029` (attr 1, tid 5, dtt 2), done with success -> `xfer_attr_o=1`, no response write, next command popped.
- **Unsupported attribute.** DWORD0 attr `3'b011`, tid 5 -> no `xfer_valid_o`, response `0xA500_0000`, `halted_o=1`. A queued command is not popped until `resume_i`.
- **NACK error.** Regular command, tid 2, `wroc=0`, done with `err=5`, `len=0` -> response `0x5200_0000`, `halted_o=1`.
- **Watchdog.** `TimeoutCycles=16`, no done -> `abort_o` high exactly 16 cycles after the dispatch handshake, response `0x8<tid>00_0000`. Done arriving on cycle 16 -> no abort, success response.
- **Reset and backpressure.** `resp_queue_wready_i=0` for 10 cycles -> response word held stable. Reset asserted during WAIT_DONE -> IDLE next cycle, with all outputs at their reset values.
